cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Per-cache miss-fill engine: one instance sits behind the I-cache and one behind the D-cache, directly downstream of the memory arbitration FSM. It latches a miss, raises busy toward the arbiter, and waits for the fetch grant. Once granted, it streams eight 16-bit word reads for the missing 16-byte block into pipelined main memory and writes each returned word into the cache data array. After the last word it writes the tag and pulses finished back to the arbiter.

## Interface
- ADDR_W, 16, address and data word width
- BLOCK_WORDS, 8, words per cache block (power of two)
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  ADDR_W  byte address of the missing access
- mem_fetch  in  1  grant from the arbiter; memory port belongs to this cache
- memory_data  in  ADDR_W  read data from memory
- memory_data_valid  in  1  memory_data is valid this cycle
- fsm_busy  out  1  to the arbiter cacheBusy input
- fill_finished  out  1  to the arbiter cache_finished input; one-cycle pulse
- mem_read_en  out  1  read request to memory this cycle
- memory_address  out  ADDR_W  request byte address
- write_data_array  out  1  write memory_data into the data array
- fill_word_idx  out  log2(BLOCK_WORDS)  word slot being written
- write_tag_array  out  1  write the tag for the latched block

## Operation
- States:
  - IDLE
  - WAIT_GRANT
  - FILL
- IDLE:
  - When miss_detected=1, latch block base = {miss_address[15:4], 4'b0}, clear req_cnt and rx_cnt, and go to WAIT_GRANT.
  - mem_fetch and memory_data_valid are ignored.
- WAIT_GRANT:
  - Hold until mem_fetch=1, then go to FILL.
  - miss_detected and miss_address are ignored; the latched base stands.
- FILL, request side:
  - While req_cnt < BLOCK_WORDS: mem_read_en=1, memory_address = base + {req_cnt, 1'b0}, req_cnt increments.
  - One request per cycle, back to back.
  - mem_read_en=0 once req_cnt reaches BLOCK_WORDS.
- FILL, return side:
  - Each memory_data_valid cycle: write_data_array=1, fill_word_idx=rx_cnt, rx_cnt increments.
  - Words are returned in request order.
- Completion:
  - On the valid cycle where rx_cnt = BLOCK_WORDS-1, write_tag_array=1 and fill_finished=1 in that same cycle.
  - Next state is IDLE.
- fsm_busy = (state != IDLE) | miss_detected. It is combinational so the arbiter sees the miss the same cycle.
- Once in FILL, mem_fetch is not re-checked. The arbiter holds the grant until it sees fill_finished.
- Counters are log2(BLOCK_WORDS)+1 bits wide, with no wrap inside a fill. The address add truncates to ADDR_W; the low 4 bits never carry.

## Timing
- Reset values:
  - state = IDLE and counters = 0.
  - All outputs 0, except memory_address, which is 0 and don't-care.
- Miss at cycle m: fsm_busy=1 at m, state WAIT_GRANT at m+1.
- Grant seen at cycle g: requests issued at cycles g+1 through g+8.
- With memory latency L, valids arrive at g+1+L through g+8+L. fill_finished is at g+8+L, and state is IDLE at g+9+L.
- Back-to-back misses: a new miss is accepted at the first IDLE cycle after a fill.
- memory_data_valid is ignored in IDLE and WAIT_GRANT, and ignored once rx_cnt = BLOCK_WORDS. Stray valids do not write.
- Reset mid-fill: return to IDLE immediately with counters cleared. Late returns from memory are ignored, because the block is in IDLE.
- If miss_detected and the final valid arrive in the same cycle, the final valid wins. The miss is re-evaluated in IDLE on the next cycle; the cache holds its miss until the fill completes.

## Structure
- Shared package:
  - State encoding: IDLE=2'b00, WAIT_GRANT=2'b01, FILL=2'b10.
  - BLOCK_WORDS and BLOCK_OFFSET_BITS=4.
  - WORD_BYTES=2.
- One natural sub-module, fill_counter: a 4-bit resettable incrementing counter with enable and a terminal-count output. It is instantiated twice, for req_cnt and rx_cnt.
- The state register uses the async active-low reset, consistent with every other flop in this block.

## Test plan
- Basic fill:
  - Stimulus: miss at 0x1236, grant 3 cycles later, memory latency 4.
  - Required: requests to 0x1230 through 0x123E, one per cycle. Eight data writes with idx 0–7. write_tag_array and fill_finished together at grant+12. IDLE the next cycle.
- Busy timing:
  - Stimulus: miss_detected in IDLE.
  - Required: fsm_busy=1 the same cycle, and it stays 1 until the cycle after fill_finished.
- Grant ordering:
  - Stimulus: mem_fetch pulsed in IDLE with no miss; then a miss with the grant withheld for 10 cycles.
  - Required: no requests before the grant. miss_address changes during WAIT_GRANT do not alter the base.
- Stray valids:
  - Stimulus: memory_data_valid asserted in IDLE, and a 9th valid after completion.
  - Required: write_data_array stays 0.
- Reset mid-fill:
  - Stimulus: rst=0 after 3 returns, then release, then a new miss at 0x0040.
  - Required: all outputs 0 during reset. The new fill starts at idx 0 and address 0x0040.
- Back-to-back fills:
  - Stimulus: miss held through completion.
  - Required: a second fill starts from IDLE, and fill_finished pulses exactly once per fill.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss-fill engine.
// Holds the block geometry, the legacy state encoding and the address helpers
// used by cache_fill_fsm, its interface and the fill_counter sub-module.
package cache_fill_fsm_pkg;

    localparam int unsigned ADDR_W            = 16;
    localparam int unsigned BLOCK_WORDS       = 8;
    localparam int unsigned IDX_W             = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W             = IDX_W + 1;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WORD_BYTES        = 2;

    // State encoding kept bit-compatible with the legacy arbiter debug taps.
    localparam logic [1:0] StIdle      = 2'b00;
    localparam logic [1:0] StWaitGrant = 2'b01;
    localparam logic [1:0] StFill      = 2'b10;

    // Base byte address of the block containing addr.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
    endfunction

    // Byte address of word slot cnt within the block; the add truncates to ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
        return base + ADDR_W'(cnt) * ADDR_W'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus bundle between the fill engine, the cache lookup, the arbiter and memory.
// slave  : the fill engine's view (lookup/arbiter/memory inputs, fill outputs).
// master : the surrounding system's view (drives inputs, observes outputs).
interface cache_fill_fsm_if
    import cache_fill_fsm_pkg::*;
();

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              mem_fetch;
    logic [ADDR_W-1:0] memory_data;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              fill_finished;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [IDX_W-1:0]  fill_word_idx;
    logic              write_tag_array;

    modport slave (
        input  miss_detected,
        input  miss_address,
        input  mem_fetch,
        input  memory_data,
        input  memory_data_valid,
        output fsm_busy,
        output fill_finished,
        output mem_read_en,
        output memory_address,
        output write_data_array,
        output fill_word_idx,
        output write_tag_array
    );

    modport master (
        output miss_detected,
        output miss_address,
        output mem_fetch,
        output memory_data,
        output memory_data_valid,
        input  fsm_busy,
        input  fill_finished,
        input  mem_read_en,
        input  memory_address,
        input  write_data_array,
        input  fill_word_idx,
        input  write_tag_array
    );

endinterface

// File: rtl/cache_fill_fsm_counter.sv
// fill_counter: resettable incrementing word counter for one side of a fill.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (takes priority over en)
//   en       : increment this cycle
//   count    : current count, 0..BLOCK_WORDS
//   tc       : terminal count, high once count has reached BLOCK_WORDS
module fill_counter
    import cache_fill_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == CNT_W'(BLOCK_WORDS));

endmodule

// File: rtl/cache_fill_fsm.sv
// Per-cache miss-fill engine. Latches a missing block, raises busy toward the
// arbiter, waits for the fetch grant, streams BLOCK_WORDS pipelined word reads
// into memory and writes each returned word into the data array. The final
// return also writes the tag and pulses fill_finished.
// Ports:
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : cache_fill_fsm_if.slave (miss/grant/memory inputs, fill outputs)
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.slave  bus
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  rx_cnt;
    logic              req_tc;
    logic              rx_tc;

    logic              in_idle;
    logic              req_active;
    logic              rx_valid;
    logic              last_word;

    assign in_idle    = (state_q == StIdle);
    assign req_active = (state_q == StFill) && !req_tc;
    // Returns outside FILL, or beyond a full block, never reach the array.
    assign rx_valid   = (state_q == StFill) && bus.memory_data_valid && !rx_tc;
    assign last_word  = rx_valid && (rx_cnt == CNT_W'(BLOCK_WORDS - 1));

    // Both counters sit cleared for the whole of IDLE, so each fill starts at 0.
    fill_counter u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_idle),
        .en    (req_active),
        .count (req_cnt),
        .tc    (req_tc)
    );

    fill_counter u_rx_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_idle),
        .en    (rx_valid),
        .count (rx_cnt),
        .tc    (rx_tc)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            StIdle: begin
                if (bus.miss_detected) begin
                    base_d  = block_base(bus.miss_address);
                    state_d = StWaitGrant;
                end
            end
            StWaitGrant: begin
                if (bus.mem_fetch) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                // Grant is not re-checked here; the arbiter holds it until finished.
                if (last_word) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Busy includes the raw miss so the arbiter sees it in the miss cycle.
    assign bus.fsm_busy         = !in_idle || bus.miss_detected;
    assign bus.mem_read_en      = req_active;
    assign bus.memory_address   = req_active ? word_addr(base_q, req_cnt) : '0;
    assign bus.write_data_array = rx_valid;
    assign bus.fill_word_idx    = rx_valid ? rx_cnt[IDX_W-1:0] : '0;
    assign bus.write_tag_array  = last_word;
    assign bus.fill_finished    = last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;
    import cache_fill_fsm_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        int          t;
        logic [15:0] d;
    } resp_t;

    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        fetch;
        logic        valid;
        logic        exp_busy;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   fin_cnt;
    int   wr_seen;
    logic prev_fin;
    logic mem_valid;
    logic [15:0] mem_data;
    logic stray_valid;

    logic [15:0] exp_req_q[$];
    logic [2:0]  exp_wr_q[$];
    resp_t       resp_q[$];
    vec_t        tbl[15];

    cache_fill_fsm_if bus ();

    cache_fill_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.memory_data_valid = mem_valid | stray_valid;
    assign bus.memory_data       = mem_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers each request LAT cycles later, in order.
    always @(posedge clk) begin
        #1;
        if (resp_q.size() > 0 && resp_q[0].t == cyc) begin
            mem_valid = 1'b1;
            mem_data  = resp_q[0].d;
            void'(resp_q.pop_front());
        end else begin
            mem_valid = 1'b0;
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_read_en) begin
            resp_t r;
            r.t = cyc + LAT;
            r.d = bus.memory_address ^ 16'h5a5a;
            resp_q.push_back(r);
            if (exp_req_q.size() == 0) begin
                chk("unexpected_req", 32'(bus.memory_address), 32'hffff_ffff);
            end else begin
                chk("req_addr", 32'(bus.memory_address), 32'(exp_req_q.pop_front()));
            end
        end
        if (bus.write_data_array) begin
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_wr", 32'(bus.fill_word_idx), 32'hffff_ffff);
            end else begin
                chk("wr_idx", 32'(bus.fill_word_idx), 32'(exp_wr_q.pop_front()));
            end
        end
        if (bus.fill_finished || bus.write_tag_array) begin
            chk("fin_tag_pair", 32'({bus.fill_finished, bus.write_tag_array}), 32'h3);
            chk("fin_with_wr", 32'(bus.write_data_array), 32'h1);
            chk("fin_one_cycle", 32'(prev_fin), 32'h0);
        end
        if (bus.fill_finished) fin_cnt++;
        prev_fin = bus.fill_finished;
    end

    task automatic push_fill(input logic [15:0] base);
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            exp_req_q.push_back(base + 16'(2 * i));
            exp_wr_q.push_back(3'(i));
        end
    endtask

    task automatic wait_fin(input int budget, output int fcyc);
        bit found;
        found = 1'b0;
        fcyc  = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            chk("busy_during_fill", 32'(bus.fsm_busy), 32'h1);
            if (bus.fill_finished) begin
                found = 1'b1;
                fcyc  = cyc;
            end
        end
        if (!found) chk("fin_timeout", 32'h0, 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.fsm_busy), 32'h0);
        chk({tag, "_fin"}, 32'(bus.fill_finished), 32'h0);
        chk({tag, "_rd"}, 32'(bus.mem_read_en), 32'h0);
        chk({tag, "_addr"}, 32'(bus.memory_address), 32'h0);
        chk({tag, "_wr"}, 32'(bus.write_data_array), 32'h0);
        chk({tag, "_idx"}, 32'(bus.fill_word_idx), 32'h0);
        chk({tag, "_tag"}, 32'(bus.write_tag_array), 32'h0);
    endtask

    // Full fill: miss at m, grant at m+gdelay, finish expected at grant+8+LAT.
    task automatic do_fill(input logic [15:0] addr, input int gdelay);
        int g;
        int f;
        push_fill({addr[15:4], 4'h0});
        tick();
        bus.miss_detected = 1'b1;
        bus.miss_address  = addr;
        @(negedge clk);
        chk("busy_on_miss", 32'(bus.fsm_busy), 32'h1);
        for (int i = 1; i < gdelay; i++) begin
            tick();
            bus.miss_detected = 1'b0;
            bus.miss_address  = 16'(~addr);
            @(negedge clk);
            chk("busy_wait_grant", 32'(bus.fsm_busy), 32'h1);
            chk("no_req_before_grant", 32'(bus.mem_read_en), 32'h0);
        end
        tick();
        bus.miss_detected = 1'b0;
        bus.mem_fetch     = 1'b1;
        g = cyc;
        wait_fin(40, f);
        chk("fin_cycle", 32'(f), 32'(g + 8 + LAT));
        tick();
        bus.mem_fetch = 1'b0;
        @(negedge clk);
        chk("idle_after_fin_busy", 32'(bus.fsm_busy), 32'h0);
        chk("idle_after_fin_rd", 32'(bus.mem_read_en), 32'h0);
    endtask

    initial begin
        int f1;
        int f2;
        int w0;
        int fc0;
        bit hit;

        checks = 0; errors = 0; cyc = 0; fin_cnt = 0; wr_seen = 0; prev_fin = 1'b0;
        mem_valid = 1'b0; mem_data = '0; stray_valid = 1'b0;
        rst = 1'b0;
        bus.miss_detected = 1'b0;
        bus.miss_address  = '0;
        bus.mem_fetch     = 1'b0;

        // Grant ordering / stray valid table: miss at 0x5678, grant withheld 10 cycles.
        tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 3; i < 13; i++) begin
            tbl[i] = '{logic'(i[0]), 16'habcd + 16'(i), 1'b0, logic'(i[1]), 1'b1, 1'b0, 1'b0};
        end
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b1;

        push_fill(16'h5670);
        foreach (tbl[i]) begin
            tick();
            bus.miss_detected = tbl[i].miss;
            bus.miss_address  = tbl[i].addr;
            bus.mem_fetch     = tbl[i].fetch;
            stray_valid       = tbl[i].valid;
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", i), 32'(bus.fsm_busy), 32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_rd", i), 32'(bus.mem_read_en), 32'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_wr", i), 32'(bus.write_data_array), 32'(tbl[i].exp_wr));
        end
        wait_fin(40, f1);
        tick();
        bus.mem_fetch = 1'b0;

        // Basic fill with timing, then a stray valid after completion.
        do_fill(16'h1236, 3);
        tick();
        stray_valid = 1'b1;
        @(negedge clk);
        chk("stray_after_fin_wr", 32'(bus.write_data_array), 32'h0);
        tick();
        stray_valid = 1'b0;

        // Reset in the middle of a fill after three returns.
        push_fill(16'h2220);
        tick();
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h2222;
        tick();
        bus.miss_detected = 1'b0;
        bus.mem_fetch     = 1'b1;
        w0  = wr_seen;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (wr_seen >= w0 + 3) hit = 1'b1;
        end
        chk("midfill_three_returns", 32'(hit), 32'h1);
        tick();
        rst           = 1'b0;
        bus.mem_fetch = 1'b0;
        exp_req_q.delete();
        exp_wr_q.delete();
        @(negedge clk);
        check_all_zero("midreset");
        repeat (2) tick();
        rst = 1'b1;
        repeat (12) tick();
        chk("late_returns_drained", 32'(resp_q.size()), 32'h0);
        do_fill(16'h0040, 2);

        // Back-to-back fills with the miss held through completion.
        fc0 = fin_cnt;
        push_fill(16'h3000);
        push_fill(16'h3000);
        tick();
        bus.miss_detected = 1'b1;
        bus.miss_address  = 16'h300a;
        bus.mem_fetch     = 1'b1;
        wait_fin(40, f1);
        wait_fin(40, f2);
        chk("b2b_second_fin_cycle", 32'(f2), 32'(f1 + 2 + 8 + LAT));
        tick();
        bus.miss_detected = 1'b0;
        bus.mem_fetch     = 1'b0;
        @(negedge clk);
        chk("b2b_idle_busy", 32'(bus.fsm_busy), 32'h0);
        chk("b2b_fin_count", 32'(fin_cnt - fc0), 32'h2);
        repeat (LAT + 2) tick();

        chk("exp_req_empty", 32'(exp_req_q.size()), 32'h0);
        chk("exp_wr_empty", 32'(exp_wr_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
